// File: rtl/gerenciador_leitura_dht_pkg.sv
// Shared definitions for the DHT22 read manager: state encoding, plausibility
// limits for the sensor data and the width of the exhausted-cycle counter.
package gerenciador_leitura_dht_pkg;

  typedef enum logic [2:0] {
    ESPERA   = 3'd0,
    SOLICITA = 3'd1,
    VALIDA   = 3'd2,
    PAUSA    = 3'd3,
    FALHA    = 3'd4
  } estado_t;

  localparam int unsigned UMID_MAX       = 1000;
  localparam int unsigned TEMP_MAG_MAX   = 800;
  localparam int          LARGURA_FALHAS = 8;

  // Temperature is sign-magnitude; a "negative zero" is treated as corrupt data.
  function automatic logic leitura_valida(input logic        chk,
                                          input logic [15:0] umid,
                                          input logic [15:0] temp);
    return chk
        && (umid <= 16'(UMID_MAX))
        && (temp[14:0] <= 15'(TEMP_MAG_MAX))
        && !(temp[15] && (temp[14:0] == 15'd0));
  endfunction

endpackage

// File: rtl/gerenciador_leitura_dht_temporizador.sv
// Cycle counter with synchronous clear, count enable and terminal-count flag.
// fim is asserted while the count equals limite; the count then holds (never wraps).
module temporizador_ciclos #(
  parameter int LARGURA = 28
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               limpa,
  input  logic               habilita,
  input  logic [LARGURA-1:0] limite,
  output logic               fim
);

  logic [LARGURA-1:0] contagem;

  assign fim = (contagem == limite);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      contagem <= '0;
    end else if (limpa) begin
      contagem <= '0;
    end else if (habilita && !fim) begin
      contagem <= contagem + LARGURA'(1);
    end
  end

endmodule

// File: rtl/gerenciador_leitura_dht.sv
// Periodic DHT22 read sequencer: requests a reading, validates it, retries with
// a pause between attempts and reports exhausted read cycles.
//
// state    | meaning
// ESPERA   | idle between read cycles, PERIODO_CICLOS long
// SOLICITA | request asserted, waiting for dados_prontos or timeout
// VALIDA   | one cycle, plausibility check of the captured sample
// PAUSA    | idle between retries, PAUSA_CICLOS long
// FALHA    | one cycle, all attempts of the read cycle failed
module gerenciador_leitura_dht
  import gerenciador_leitura_dht_pkg::*;
#(
  parameter int unsigned PERIODO_CICLOS = 200_000_000,
  parameter int unsigned TIMEOUT_CICLOS = 10_000_000,
  parameter int unsigned PAUSA_CICLOS   = 200_000_000,
  parameter int unsigned MAX_TENTATIVAS = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic                      iniciar_leitura,
  input  logic                      dados_prontos,
  input  logic                      checksum_ok,
  input  logic [15:0]               umidade_in,
  input  logic [15:0]               temperatura_in,
  output logic [15:0]               umidade_out,
  output logic [15:0]               temperatura_out,
  output logic                      dado_valido,
  output logic                      erro,
  output logic [LARGURA_FALHAS-1:0] contagem_falhas,
  output logic [2:0]                estado
);

  localparam int unsigned MAIOR_AB = (PERIODO_CICLOS > TIMEOUT_CICLOS) ? PERIODO_CICLOS : TIMEOUT_CICLOS;
  localparam int unsigned MAIOR    = (MAIOR_AB > PAUSA_CICLOS) ? MAIOR_AB : PAUSA_CICLOS;
  localparam int          LARGURA_TMP = (MAIOR > 1) ? $clog2(MAIOR) : 1;
  localparam logic [2:0]  MAX_T = 3'(MAX_TENTATIVAS);

  estado_t estado_atual, estado_prox;

  logic                   dp_ant;
  logic                   borda;
  logic                   chk_cap;
  logic [15:0]            umid_cap;
  logic [15:0]            temp_cap;
  logic [2:0]             tentativas;
  logic                   inicia_ciclo;
  logic                   falha_tentativa;
  logic                   aprova;
  logic                   tmp_limpa;
  logic                   tmp_habilita;
  logic                   tmp_fim;
  logic [LARGURA_TMP-1:0] tmp_limite;

  assign borda  = dados_prontos && !dp_ant;
  assign estado = estado_atual;

  // One timer shared by all timed states; it restarts on every state change.
  assign tmp_limpa    = (estado_prox != estado_atual);
  assign tmp_habilita = (estado_atual == ESPERA) || (estado_atual == SOLICITA)
                     || (estado_atual == PAUSA);

  always_comb begin
    tmp_limite = '0;
    case (estado_atual)
      ESPERA:   tmp_limite = LARGURA_TMP'(PERIODO_CICLOS - 1);
      SOLICITA: tmp_limite = LARGURA_TMP'(TIMEOUT_CICLOS - 1);
      PAUSA:    tmp_limite = LARGURA_TMP'(PAUSA_CICLOS - 1);
      default:  tmp_limite = '0;
    endcase
  end

  temporizador_ciclos #(
    .LARGURA (LARGURA_TMP)
  ) u_temporizador (
    .clk      (clk),
    .reset_n  (reset_n),
    .limpa    (tmp_limpa),
    .habilita (tmp_habilita),
    .limite   (tmp_limite),
    .fim      (tmp_fim)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_atual <= ESPERA;
    end else begin
      estado_atual <= estado_prox;
    end
  end

  always_comb begin
    estado_prox     = estado_atual;
    inicia_ciclo    = 1'b0;
    falha_tentativa = 1'b0;
    aprova          = 1'b0;
    case (estado_atual)
      ESPERA: begin
        if (tmp_fim) begin
          estado_prox  = SOLICITA;
          inicia_ciclo = 1'b1;
        end
      end
      SOLICITA: begin
        // A data edge on the timeout cycle still counts as a response.
        if (borda) begin
          estado_prox = VALIDA;
        end else if (tmp_fim) begin
          falha_tentativa = 1'b1;
        end
      end
      VALIDA: begin
        if (leitura_valida(chk_cap, umid_cap, temp_cap)) begin
          aprova      = 1'b1;
          estado_prox = ESPERA;
        end else begin
          falha_tentativa = 1'b1;
        end
      end
      PAUSA: begin
        if (tmp_fim) begin
          estado_prox = SOLICITA;
        end
      end
      FALHA:   estado_prox = ESPERA;
      default: estado_prox = ESPERA;
    endcase
    if (falha_tentativa) begin
      estado_prox = (tentativas < MAX_T) ? PAUSA : FALHA;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_ant          <= 1'b0;
      iniciar_leitura <= 1'b0;
      erro            <= 1'b0;
      tentativas      <= '0;
      chk_cap         <= 1'b0;
      umid_cap        <= '0;
      temp_cap        <= '0;
      umidade_out     <= '0;
      temperatura_out <= '0;
      dado_valido     <= 1'b0;
      contagem_falhas <= '0;
    end else begin
      dp_ant          <= dados_prontos;
      iniciar_leitura <= (estado_prox == SOLICITA);
      erro            <= (estado_prox == FALHA);

      if (inicia_ciclo) begin
        tentativas <= 3'd1;
      end else if (falha_tentativa && (estado_prox == PAUSA)) begin
        tentativas <= tentativas + 3'd1;
      end

      if ((estado_atual == SOLICITA) && borda) begin
        chk_cap  <= checksum_ok;
        umid_cap <= umidade_in;
        temp_cap <= temperatura_in;
      end

      if (aprova) begin
        umidade_out     <= umid_cap;
        temperatura_out <= temp_cap;
        dado_valido     <= 1'b1;
      end

      if (estado_prox == FALHA) begin
        dado_valido <= 1'b0;
        if (contagem_falhas != '1) begin
          contagem_falhas <= contagem_falhas + LARGURA_FALHAS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gerenciador_leitura_dht.sv
// Randomized bench for gerenciador_leitura_dht, checked against a read-cycle
// level model of requests, gaps, validation outcomes and failure accounting.
module tb_gerenciador_leitura_dht;
  import gerenciador_leitura_dht_pkg::*;

  localparam int PERIODO = 100;
  localparam int TIMEOUT = 50;
  localparam int PAUSA_C = 20;
  localparam int MAXT    = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        dados_prontos = 1'b0;
  logic        checksum_ok = 1'b0;
  logic [15:0] umidade_in = '0;
  logic [15:0] temperatura_in = '0;
  logic        iniciar_leitura;
  logic [15:0] umidade_out;
  logic [15:0] temperatura_out;
  logic        dado_valido;
  logic        erro;
  logic [7:0]  contagem_falhas;
  logic [2:0]  estado;

  gerenciador_leitura_dht #(
    .PERIODO_CICLOS (PERIODO),
    .TIMEOUT_CICLOS (TIMEOUT),
    .PAUSA_CICLOS   (PAUSA_C),
    .MAX_TENTATIVAS (MAXT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .iniciar_leitura (iniciar_leitura),
    .dados_prontos   (dados_prontos),
    .checksum_ok     (checksum_ok),
    .umidade_in      (umidade_in),
    .temperatura_in  (temperatura_in),
    .umidade_out     (umidade_out),
    .temperatura_out (temperatura_out),
    .dado_valido     (dado_valido),
    .erro            (erro),
    .contagem_falhas (contagem_falhas),
    .estado          (estado)
  );

  always #5 clk = ~clk;

  int ciclo = 0;
  always @(posedge clk) ciclo <= ciclo + 1;

  int erros_vistos = 0;
  always @(negedge clk) if (erro === 1'b1) erros_vistos++;

  int checks = 0;
  int erros  = 0;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s: obtido=%0h esperado=%0h (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  // Reference model state
  logic [15:0] m_umid = '0;
  logic [15:0] m_temp = '0;
  bit          m_valido = 1'b0;
  int          m_falhas = 0;
  int          m_erros_total = 0;
  int          t_desce = 0;
  int          gap = PERIODO;

  // Per-attempt reader behaviour for the next read cycle
  bit          p_resp [MAXT];
  int          p_k    [MAXT];
  bit          p_chk  [MAXT];
  logic [15:0] p_u    [MAXT];
  logic [15:0] p_t    [MAXT];

  function automatic bit aceita(input bit chk, input logic [15:0] u, input logic [15:0] t);
    int valor;
    int mag;
    bit neg;
    valor = int'(t);
    neg   = (valor >= 32768);
    mag   = valor % 32768;
    return chk && (int'(u) <= 1000) && (mag <= 800) && !(neg && mag == 0);
  endfunction

  function automatic logic [15:0] sorteia_umid();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(0, 1000));
      1:       return 16'd1000;
      2:       return 16'd1001;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] sorteia_temp();
    int mag;
    case ($urandom_range(0, 4))
      0:       mag = 0;
      1:       mag = 800;
      2:       mag = 801;
      3:       mag = $urandom_range(0, 800);
      default: mag = $urandom_range(0, 32767);
    endcase
    return 16'(($urandom_range(0, 1) * 32768) + mag);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic planeja(input int a, input bit resp, input int k, input bit chk,
                         input logic [15:0] u, input logic [15:0] t);
    p_resp[a] = resp; p_k[a] = k; p_chk[a] = chk; p_u[a] = u; p_t[a] = t;
  endtask

  task automatic silencio();
    for (int a = 0; a < MAXT; a++) planeja(a, 1'b0, 0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic planeja_aleatorio();
    for (int a = 0; a < MAXT; a++)
      planeja(a, $urandom_range(0, 9) < 8, $urandom_range(0, TIMEOUT - 1),
              $urandom_range(0, 3) != 0, sorteia_umid(), sorteia_temp());
  endtask

  task automatic ciclo_leitura();
    int t_sobe;
    bit viu;
    bit ok;
    for (int a = 0; a < MAXT; a++) begin
      viu = 1'b0;
      for (int n = 0; n < gap + 20; n++) begin
        if (iniciar_leitura === 1'b1) begin
          viu = 1'b1;
          break;
        end
        // Reader noise while idle must not start anything.
        if (ciclo - t_desce < gap - 3) begin
          dados_prontos  = 1'($urandom);
          checksum_ok    = 1'($urandom);
          umidade_in     = 16'($urandom);
          temperatura_in = 16'($urandom);
        end else begin
          dados_prontos = 1'b0;
        end
        tick();
      end
      verifica("pedido_visto", 32'(viu), 32'd1);
      if (!viu) return;
      t_sobe = ciclo;
      verifica("intervalo_baixo", 32'(t_sobe - t_desce), 32'(gap));

      if (p_resp[a]) begin
        repeat (p_k[a]) tick();
        dados_prontos  = 1'b1;
        checksum_ok    = p_chk[a];
        umidade_in     = p_u[a];
        temperatura_in = p_t[a];
      end
      viu = 1'b0;
      for (int n = 0; n < TIMEOUT + 10; n++) begin
        tick();
        if (iniciar_leitura === 1'b0) begin
          viu = 1'b1;
          break;
        end
      end
      verifica("pedido_caiu", 32'(viu), 32'd1);
      if (!viu) return;
      t_desce = ciclo;
      dados_prontos  = 1'b0;
      checksum_ok    = ~p_chk[a];
      umidade_in     = 16'($urandom);
      temperatura_in = 16'($urandom);
      verifica("duracao_alto", 32'(t_desce - t_sobe), 32'(p_resp[a] ? p_k[a] + 1 : TIMEOUT));
      if (p_resp[a]) begin
        verifica("estado_valida", 32'(estado), 32'(VALIDA));
        tick();
      end

      ok = p_resp[a] && aceita(p_chk[a], p_u[a], p_t[a]);
      if (ok) begin
        m_umid = p_u[a]; m_temp = p_t[a]; m_valido = 1'b1;
        verifica("estado_espera", 32'(estado), 32'(ESPERA));
        verifica("umidade_out", 32'(umidade_out), 32'(m_umid));
        verifica("temperatura_out", 32'(temperatura_out), 32'(m_temp));
        verifica("dado_valido_ok", 32'(dado_valido), 32'd1);
        verifica("erro_ok", 32'(erro), 32'd0);
        verifica("falhas_ok", 32'(contagem_falhas), 32'(m_falhas));
        gap = 1 + PERIODO;
        return;
      end else if (a < MAXT - 1) begin
        verifica("estado_pausa", 32'(estado), 32'(PAUSA));
        verifica("erro_retentativa", 32'(erro), 32'd0);
        verifica("dado_valido_retentativa", 32'(dado_valido), 32'(m_valido));
        gap = (p_resp[a] ? 1 : 0) + PAUSA_C;
      end else begin
        m_falhas = (m_falhas < 255) ? m_falhas + 1 : 255;
        m_valido = 1'b0;
        m_erros_total++;
        verifica("estado_falha", 32'(estado), 32'(FALHA));
        verifica("erro_pulso", 32'(erro), 32'd1);
        verifica("dado_valido_falha", 32'(dado_valido), 32'd0);
        verifica("falhas_contagem", 32'(contagem_falhas), 32'(m_falhas));
        verifica("umidade_mantida", 32'(umidade_out), 32'(m_umid));
        verifica("temperatura_mantida", 32'(temperatura_out), 32'(m_temp));
        tick();
        verifica("erro_um_ciclo", 32'(erro), 32'd0);
        gap = (p_resp[a] ? 1 : 0) + 1 + PERIODO;
      end
    end
  endtask

  task automatic checa_reset(input string tag);
    verifica({tag, "_iniciar"}, 32'(iniciar_leitura), 32'd0);
    verifica({tag, "_umid"}, 32'(umidade_out), 32'd0);
    verifica({tag, "_temp"}, 32'(temperatura_out), 32'd0);
    verifica({tag, "_valido"}, 32'(dado_valido), 32'd0);
    verifica({tag, "_erro"}, 32'(erro), 32'd0);
    verifica({tag, "_falhas"}, 32'(contagem_falhas), 32'd0);
    verifica({tag, "_estado"}, 32'(estado), 32'(ESPERA));
  endtask

  task automatic libera_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    t_desce = ciclo;
    gap     = PERIODO;
    m_umid = '0; m_temp = '0; m_valido = 1'b0; m_falhas = 0;
  endtask

  initial begin
    #980_000;
    $display("FAIL watchdog: simulacao excedeu o limite de tempo");
    $fatal(1, "watchdog");
  end

  initial begin
    bit viu;
    #1 reset_n = 1'b0;
    #1 checa_reset("reset_inicial");
    libera_reset();

    planeja(0, 1'b1, 10, 1'b1, 16'h0259, 16'h00FA);
    ciclo_leitura();
    planeja(0, 1'b1, 7, 1'b1, 16'h01F4, 16'h8065);
    ciclo_leitura();
    planeja(0, 1'b1, 12, 1'b1, 16'h0200, 16'h8000);
    planeja(1, 1'b1, 3, 1'b1, 16'h0210, 16'h0101);
    ciclo_leitura();
    planeja(0, 1'b1, 20, 1'b0, 16'h0300, 16'h0100);
    planeja(1, 1'b1, 4, 1'b1, 16'h0301, 16'h0102);
    ciclo_leitura();
    silencio();
    ciclo_leitura();
    planeja(0, 1'b1, TIMEOUT - 1, 1'b1, 16'd1000, 16'd800);
    ciclo_leitura();

    for (int r = 0; r < 12; r++) begin
      planeja_aleatorio();
      ciclo_leitura();
    end

    // Asynchronous reset while a request is pending
    viu = 1'b0;
    for (int n = 0; n < gap + 20; n++) begin
      if (iniciar_leitura === 1'b1) begin
        viu = 1'b1;
        break;
      end
      tick();
    end
    verifica("pedido_antes_reset", 32'(viu), 32'd1);
    repeat (5) tick();
    #2 reset_n = 1'b0;
    #1 checa_reset("reset_meio");
    libera_reset();
    planeja(0, 1'b1, 2, 1'b1, 16'h0123, 16'h0045);
    ciclo_leitura();

    silencio();
    for (int r = 0; r < 256; r++) ciclo_leitura();
    verifica("falhas_saturada", 32'(contagem_falhas), 32'd255);
    verifica("total_pulsos_erro", 32'(erros_vistos), 32'(m_erros_total));

    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule

// File: doc/gerenciador_leitura_dht.md
GERENCIADOR_LEITURA_DHT -- requirements
Module: gerenciador_leitura_dht

Interface
REQ-001 Parameter PERIODO_CICLOS, default 200_000_000, cycles between completed read cycles (2 s at 100 MHz).
REQ-002 Parameter TIMEOUT_CICLOS, default 10_000_000, max cycles waiting for dados_prontos per attempt.
REQ-003 Parameter PAUSA_CICLOS, default 200_000_000, idle cycles before a retry.
REQ-004 Parameter MAX_TENTATIVAS, default 3, attempts per read cycle (1..7).
REQ-005 clk  input  1  single system clock, all logic on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 iniciar_leitura  output  1  level request to the DHT22 reader, high for the whole attempt.
REQ-008 dados_prontos  input  1  reader completion flag, rising edge significant.
REQ-009 checksum_ok  input  1  reader checksum status, sampled with the dados_prontos edge.
REQ-010 umidade_in  input  16  raw humidity, tenths of %RH.
REQ-011 temperatura_in  input  16  raw temperature, bit 15 sign, bits 14:0 magnitude in tenths of °C.
REQ-012 umidade_out  output  16  last validated humidity.
REQ-013 temperatura_out  output  16  last validated temperature, same format as input.
REQ-014 dado_valido  output  1  high once at least one read is validated, low after an exhausted read cycle.
REQ-015 erro  output  1  one-cycle pulse when all attempts of a read cycle fail.
REQ-016 contagem_falhas  output  8  count of exhausted read cycles, saturating.
REQ-017 estado  output  3  current FSM state encoding, for debug LEDs.

Function
REQ-018 FSM states: ESPERA, SOLICITA, VALIDA, PAUSA, FALHA.
REQ-019 ESPERA: count PERIODO_CICLOS cycles; at terminal count go to SOLICITA, attempt counter = 1.
REQ-020 SOLICITA: iniciar_leitura = 1; timeout counter runs from 0; registered rising edge of dados_prontos -> VALIDA with inputs captured that cycle; count reaching TIMEOUT_CICLOS -> attempt failed.
REQ-021 Same-cycle dados_prontos edge and timeout: data edge wins.
REQ-022 Edges of dados_prontos outside SOLICITA are ignored.
REQ-023 VALIDA lasts one cycle; pass requires checksum_ok = 1, umidade <= 1000, temperature magnitude <= 800, and not (sign = 1 and magnitude = 0).
REQ-024 Pass: latch umidade_out/temperatura_out, dado_valido = 1, next state ESPERA.
REQ-025 Failed attempt (check or timeout): attempts < MAX_TENTATIVAS -> PAUSA, increment attempts; else -> FALHA.
REQ-026 PAUSA: count PAUSA_CICLOS cycles, then SOLICITA.
REQ-027 FALHA lasts one cycle: erro = 1, dado_valido = 0, contagem_falhas += 1 saturating at 255; outputs keep last latched values; next ESPERA.
REQ-028 iniciar_leitura falls the cycle after leaving SOLICITA; minimum low time between attempts is PAUSA_CICLOS or PERIODO_CICLOS.
REQ-029 Timers restart at 0 on every state entry; no counter wraps.

Reset
REQ-030 reset_n low: state ESPERA, timers 0, attempts 0, iniciar_leitura 0, umidade_out 0, temperatura_out 0, dado_valido 0, erro 0, contagem_falhas 0, edge-detect register 0.
REQ-031 Reset mid-attempt drops iniciar_leitura immediately (asynchronous); after release the first request comes PERIODO_CICLOS cycles later.

Structure
REQ-032 Shared package holds the state encoding, UMID_MAX = 1000, TEMP_MAG_MAX = 800 and the failure-count width.
REQ-033 One sub-module, temporizador_ciclos: clear/enable cycle counter with terminal-count output, instantiated once and shared by ESPERA, SOLICITA and PAUSA.
REQ-034 Top-level integration drives the reader's iniciar_leitura from this block and routes umidade_out/temperatura_out to the display mux.

Verification (PERIODO=100, TIMEOUT=50, PAUSA=20, MAX=3)
REQ-035 Nominal: edge at cycle 10 of SOLICITA, checksum_ok=1, umidade 0x0259, temp 0x00FA -> outputs latched, dado_valido=1, ESPERA 2 cycles after edge.
REQ-036 Negative temperature 0x8065 (-10.1 °C), checksum ok -> accepted; 0x8000 -> rejected, PAUSA entered.
REQ-037 Reader silent: 3 timeouts, each after 50 cycles of iniciar_leitura high with 20-cycle gaps -> erro pulse, contagem_falhas 1, dado_valido 0, previous values held.
REQ-038 checksum_ok=0 on attempt 1, valid on attempt 2 -> no erro, values latched, contagem_falhas unchanged.
REQ-039 Edge on the timeout cycle -> treated as data; 256 exhausted cycles -> contagem_falhas stays 255.
REQ-040 reset_n low during SOLICITA -> iniciar_leitura 0 without a clock edge; all outputs at reset values; next request exactly 100 cycles after release.
